mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle RV32I control unit; the sequential successor of the single-cycle decoder.
//  Walks FETCH/DECODE/EXEC/MEM/WB per instruction and waits on a memory ready handshake.
//  Adds the full branch set, JALR, AUIPC, byte/half loads and stores, illegal-op trap and retire counter.
//  Sits between the IR/datapath and the shared ALU, EXT, NPC and DM blocks.
//  Encodings come from ctrl_encode_def.v.
// PARAMETERS
//  ALUOP_W   5   ALUOp width (ALUOp_* codes)
//  EXTOP_W   6   EXTOp one-hot width (EXT_CTRL_*)
//  CNT_W     32  retired-instruction counter width
//  MEM_WAIT  1   1: FETCH and MEM hold until mem_ready; 0: mem_ready is ignored (treated as 1)
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  Op         in   7        opcode field of IR
//  Funct7     in   7        funct7 field of IR
//  Funct3     in   3        funct3 field of IR
//  Zero       in   1        ALU result == 0
//  Lt         in   1        signed rs1 < rs2, from the ALU compare
//  Ltu        in   1        unsigned rs1 < rs2
//  mem_ready  in   1        IM/DM access complete this cycle
//  PCWrite    out  1        PC load strobe
//  IRWrite    out  1        IR load strobe
//  RegWrite   out  1        RF write strobe
//  MemRead    out  1        DM read request
//  MemWrite   out  1        DM write request
//  DMType     out  3        funct3 passthrough for lb/lh/lw/lbu/lhu/sb/sh/sw
//  EXTOp      out  EXTOP_W  immediate type
//  ALUOp      out  ALUOP_W  ALU operation
//  ALUSrcA    out  1        ALU A operand: 0 = rs1, 1 = PC (AUIPC)
//  ALUSrc     out  1        ALU B operand: 1 = immediate
//  NPCOp      out  3        next-PC select (NPC_*), valid only while PCWrite=1
//  WDSel      out  2        write-back select (WDSel_From*)
//  illegal    out  1        sticky illegal-instruction flag
//  retire     out  1        one-cycle pulse when an instruction completes
//  instr_cnt  out  CNT_W    retired-instruction count; wraps to 0 at overflow
// BEHAVIOUR
//  - State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
//    State, illegal and instr_cnt are registers; all other outputs are decoded from state plus Op/Funct.
//  - Reset (any state, including mid-access): next edge state=FETCH, illegal=0, instr_cnt=0.
//    All strobes stay 0 while reset=1.
//  - FETCH: MemRead=1. On mem_ready: IRWrite=1, PCWrite=1, NPCOp=PLUS4, next=DECODE.
//    Otherwise hold with no strobes.
//  - DECODE: next=TRAP if Op/Funct is not RV32I; next=EXEC otherwise.
//  - EXEC: ALUOp, ALUSrc, ALUSrcA and EXTOp driven per instruction.
//    Load/store -> MEM. R/I-ALU/LUI/AUIPC -> WB.
//    Branch: PCWrite=1, NPCOp=BRANCH when taken (beq Zero, bne ~Zero, blt Lt, bge ~Lt, bltu Ltu, bgeu ~Ltu).
//    A branch then goes to FETCH with retire=1.
//    JAL/JALR: RegWrite=1, WDSel=FromPC, PCWrite=1, NPCOp=JUMP or JALR, retire=1, next=FETCH.
//  - MEM: load MemRead=1, store MemWrite=1, both with DMType=Funct3.
//    Hold until mem_ready; on mem_ready the request drops.
//    Store -> FETCH with retire=1. Load -> WB.
//  - WB: RegWrite=1, WDSel=FromMEM for loads and FromALU otherwise; retire=1; next=FETCH.
//  - TRAP: illegal=1 and stays 1 until reset; no strobes; the FSM holds in TRAP.
//  - Latency in cycles, excluding memory wait: ALU 4, load 5, store 4, branch 3, jal/jalr 3.
//    Each mem_ready=0 cycle adds 1 cycle.
//  - instr_cnt increments on the same edge that retire=1 is sampled; all-ones + 1 -> 0.
//  - Shift immediates use EXTOp=ITYPE_SHAMT. srai is distinguished by Funct7[5].
//    Any other non-zero Funct7 bits on a shift or R-type instruction -> TRAP.
// TESTING
//  add x3,x1,x2 with mem_ready=1 -> states F,D,E,W; RegWrite=1 in cycle 4 only; retire=1 once; instr_cnt=1.
//  lw with mem_ready low 3 cycles in MEM -> MemRead held 4 cycles; WDSel=01 in WB; total 8 cycles.
//  bge with Lt=0 -> NPCOp=001 and PCWrite in EXEC; with Lt=1 -> NPCOp=000 (PC+4 already taken).
//  Op=7'b1111111 -> TRAP after DECODE; illegal=1; no strobes for 10 cycles; reset -> FETCH, illegal=0.
//  reset asserted in MEM during sw -> MemWrite=0 on that cycle; FETCH on next edge; instr_cnt=0.
//  CNT_W=4: run 16 addi -> instr_cnt wraps to 0; retire pulse count = 16.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RV32I control FSM with memory handshake, illegal-op trap and retire counter
module mc_ctrl #(
  parameter int ALUOP_W  = 5,
  parameter int EXTOP_W  = 6,
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Op,
  input  logic [6:0]         Funct7,
  input  logic [2:0]         Funct3,
  input  logic               Zero,
  input  logic               Lt,
  input  logic               Ltu,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [2:0]         DMType,
  output logic [EXTOP_W-1:0] EXTOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUSrcA,
  output logic               ALUSrc,
  output logic [2:0]         NPCOp,
  output logic [1:0]         WDSel,
  output logic               illegal,
  output logic               retire,
  output logic [CNT_W-1:0]   instr_cnt
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [4:0] AOP_NOP = 5'd0, AOP_LUI = 5'd1, AOP_ADD = 5'd2, AOP_SUB = 5'd3, AOP_SLL = 5'd4, AOP_SLT = 5'd5;
  localparam logic [4:0] AOP_SLTU = 5'd6, AOP_XOR = 5'd7, AOP_SRL = 5'd8, AOP_SRA = 5'd9, AOP_OR = 5'd10, AOP_AND = 5'd11;
  localparam logic [5:0] EXT_SHAMT = 6'b100000, EXT_I = 6'b010000, EXT_S = 6'b001000;
  localparam logic [5:0] EXT_B = 6'b000100, EXT_U = 6'b000010, EXT_J = 6'b000001;
  localparam logic [2:0] NPC_PLUS4 = 3'b000, NPC_BRANCH = 3'b001, NPC_JUMP = 3'b010, NPC_JALR = 3'b100;
  localparam logic [1:0] WD_ALU = 2'b00, WD_MEM = 2'b01, WD_PC = 2'b10;
  state_t r_state;
  logic r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic w_r, w_i, w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_auipc, w_alt, w_legal, w_rdy, w_taken;
  logic w_f, w_e, w_m, w_w, w_x, w_jmp;
  logic [4:0] w_aop;
  logic [5:0] w_ext;
  assign w_r     = Op == OP_R;
  assign w_i     = Op == OP_I;
  assign w_ld    = Op == OP_LD;
  assign w_st    = Op == OP_ST;
  assign w_br    = Op == OP_BR;
  assign w_jal   = Op == OP_JAL;
  assign w_jalr  = Op == OP_JALR;
  assign w_lui   = Op == OP_LUI;
  assign w_auipc = Op == OP_AUIPC;
  assign w_jmp   = w_jal || w_jalr;
  assign w_alt   = Funct7 == 7'b0100000;
  assign w_rdy   = !MEM_WAIT || mem_ready;
  // Only sub/sra (and srai) may carry the alternate funct7; anything else non-zero is not RV32I.
  assign w_legal = w_r    ? (Funct7 == 7'd0 || (w_alt && (Funct3 == 3'b000 || Funct3 == 3'b101))) :
                   w_i    ? (Funct3 == 3'b001 ? Funct7 == 7'd0 : Funct3 == 3'b101 ? (Funct7 == 7'd0 || w_alt) : 1'b1) :
                   w_ld   ? (Funct3 != 3'b011 && Funct3[2:1] != 2'b11) :
                   w_st   ? (!Funct3[2] && Funct3 != 3'b011) :
                   w_br   ? Funct3[2:1] != 2'b01 :
                   w_jalr ? Funct3 == 3'b000 :
                   (w_jal || w_lui || w_auipc);
  assign w_taken = (Funct3[2] ? (Funct3[1] ? Ltu : Lt) : Zero) ^ Funct3[0];
  assign w_ext   = w_i ? (Funct3[1:0] == 2'b01 ? EXT_SHAMT : EXT_I) :
                   (w_ld || w_jalr) ? EXT_I : w_st ? EXT_S : w_br ? EXT_B :
                   (w_lui || w_auipc) ? EXT_U : w_jal ? EXT_J : 6'd0;
  always_comb begin
    w_aop = AOP_ADD;
    if (w_r || w_i)
      case (Funct3)
        3'b000:  w_aop = (w_r && Funct7[5]) ? AOP_SUB : AOP_ADD;
        3'b001:  w_aop = AOP_SLL;
        3'b010:  w_aop = AOP_SLT;
        3'b011:  w_aop = AOP_SLTU;
        3'b100:  w_aop = AOP_XOR;
        3'b101:  w_aop = Funct7[5] ? AOP_SRA : AOP_SRL;
        3'b110:  w_aop = AOP_OR;
        default: w_aop = AOP_AND;
      endcase
    else if (w_br)
      w_aop = AOP_SUB;
    else if (w_lui)
      w_aop = AOP_LUI;
    else if (w_jal)
      w_aop = AOP_NOP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (retire) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        FETCH:  if (w_rdy) r_state <= DECODE;
        DECODE: begin
          r_state <= w_legal ? EXEC : TRAP;
          if (!w_legal) r_illegal <= 1'b1;
        end
        EXEC:   r_state <= (w_ld || w_st) ? MEM : (w_br || w_jmp) ? FETCH : WB;
        MEM:    if (w_rdy) r_state <= w_ld ? WB : FETCH;
        WB:     r_state <= FETCH;
        default: r_state <= TRAP;
      endcase
    end
  end
  assign w_f = !reset && r_state == FETCH;
  assign w_e = !reset && r_state == EXEC;
  assign w_m = !reset && r_state == MEM;
  assign w_w = !reset && r_state == WB;
  assign w_x = w_e || w_m || w_w;
  assign MemRead   = w_f || (w_m && w_ld);
  assign MemWrite  = w_m && w_st;
  assign IRWrite   = w_f && w_rdy;
  assign PCWrite   = IRWrite || (w_e && ((w_br && w_taken) || w_jmp));
  assign NPCOp     = (w_e && w_br && w_taken) ? NPC_BRANCH : (w_e && w_jal) ? NPC_JUMP :
                     (w_e && w_jalr) ? NPC_JALR : NPC_PLUS4;
  assign RegWrite  = w_w || (w_e && w_jmp);
  assign WDSel     = (w_e && w_jmp) ? WD_PC : (w_w && w_ld) ? WD_MEM : WD_ALU;
  assign retire    = w_w || (w_e && (w_br || w_jmp)) || (w_m && w_st && w_rdy);
  assign DMType    = w_m ? Funct3 : 3'b000;
  assign ALUOp     = w_x ? ALUOP_W'(w_aop) : '0;
  assign EXTOp     = w_x ? EXTOP_W'(w_ext) : '0;
  assign ALUSrc    = w_x && (w_i || w_ld || w_st || w_jalr || w_lui || w_auipc);
  assign ALUSrcA   = w_x && w_auipc;
  assign illegal   = r_illegal;
  assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl; a CNT_W=4 copy shares the inputs to exercise counter wrap
module tb_mc_ctrl;
  logic clk = 1'b0, reset = 1'b1, Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0, mem_ready = 1'b1;
  logic [6:0] Op = 7'd0, Funct7 = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrc, illegal, retire;
  logic [2:0] DMType, NPCOp;
  logic [5:0] EXTOp;
  logic [4:0] ALUOp;
  logic [1:0] WDSel;
  logic [31:0] instr_cnt;
  logic s_pcw, s_irw, s_rw, s_mr, s_mw, s_srca, s_src, s_ill, s_retire;
  logic [2:0] s_dm, s_npc;
  logic [5:0] s_ext;
  logic [4:0] s_aop;
  logic [1:0] s_wd;
  logic [3:0] s_instr_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .DMType(DMType), .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrc(ALUSrc),
    .NPCOp(NPCOp), .WDSel(WDSel), .illegal(illegal), .retire(retire), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .Op(Op), .Funct7(Funct7), .Funct3(Funct3), .Zero(Zero), .Lt(Lt), .Ltu(Ltu),
    .mem_ready(mem_ready), .PCWrite(s_pcw), .IRWrite(s_irw), .RegWrite(s_rw), .MemRead(s_mr),
    .MemWrite(s_mw), .DMType(s_dm), .EXTOp(s_ext), .ALUOp(s_aop), .ALUSrcA(s_srca), .ALUSrc(s_src),
    .NPCOp(s_npc), .WDSel(s_wd), .illegal(s_ill), .retire(s_retire), .instr_cnt(s_instr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    Op = op;
    Funct3 = f3;
    Funct7 = f7;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH until retire; fst fetch stalls, mst memory stalls.
  task automatic run_instr(input int fst, input int mst, output int cyc, output int nrw, output int nmr,
                           output int nmw, output logic [1:0] wd, output logic [2:0] dm);
    int m;
    bit done;
    m = mst;
    done = 0;
    cyc = 0; nrw = 0; nmr = 0; nmw = 0; wd = 2'b11; dm = 3'b111;
    while (!done && cyc < 40) begin
      mem_ready = 1'b1;
      #1;
      if (cyc < fst) mem_ready = 1'b0;
      else if (cyc > fst && (MemRead || MemWrite) && m > 0) begin
        mem_ready = 1'b0;
        m--;
      end
      #1;
      nrw += int'(RegWrite);
      nmr += int'(MemRead);
      nmw += int'(MemWrite);
      if (cyc > fst && (MemRead || MemWrite)) dm = DMType;
      if (retire) begin
        done = 1;
        wd = WDSel;
      end
      cyc++;
      step();
    end
    mem_ready = 1'b1;
    total++;
    if (!done) begin bad++; $display("FAIL run_instr_timeout got=no_retire exp=retire within 40 cycles"); end
  endtask

  task automatic test_reset();
    set_ir(7'b0110011, 3'b000, 7'd0);
    reset = 1'b1;
    step();
    total++; if (MemRead !== 1'b0) begin bad++; $display("FAIL rst_memread got=%0b exp=0", MemRead); end
    total++; if (IRWrite !== 1'b0) begin bad++; $display("FAIL rst_irwrite got=%0b exp=0", IRWrite); end
    total++; if (PCWrite !== 1'b0) begin bad++; $display("FAIL rst_pcwrite got=%0b exp=0", PCWrite); end
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", instr_cnt); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0b exp=0", illegal); end
    reset = 1'b0;
    #1;
    total++; if (MemRead !== 1'b1) begin bad++; $display("FAIL rst_fetch_memread got=%0b exp=1", MemRead); end
    total++; if (IRWrite !== 1'b1) begin bad++; $display("FAIL rst_fetch_irwrite got=%0b exp=1", IRWrite); end
    total++; if (NPCOp !== 3'b000) begin bad++; $display("FAIL rst_fetch_npc got=%0b exp=000", NPCOp); end
  endtask

  task automatic test_add();
    int nrw;
    nrw = 0;
    set_ir(7'b0110011, 3'b000, 7'd0);
    mem_ready = 1'b1;
    #1;
    nrw += int'(RegWrite);
    total++; if (PCWrite !== 1'b1) begin bad++; $display("FAIL add_f_pcwrite got=%0b exp=1", PCWrite); end
    step();
    nrw += int'(RegWrite);
    total++; if ({MemRead, IRWrite, PCWrite, MemWrite} !== 4'b0000) begin bad++; $display("FAIL add_d_strobes got=%b exp=0000", {MemRead, IRWrite, PCWrite, MemWrite}); end
    step();
    nrw += int'(RegWrite);
    total++; if (ALUOp !== 5'd2) begin bad++; $display("FAIL add_e_aluop got=%0d exp=2", ALUOp); end
    total++; if (ALUSrc !== 1'b0) begin bad++; $display("FAIL add_e_alusrc got=%0b exp=0", ALUSrc); end
    total++; if (retire !== 1'b0) begin bad++; $display("FAIL add_e_retire got=%0b exp=0", retire); end
    step();
    nrw += int'(RegWrite);
    total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL add_w_regwrite got=%0b exp=1", RegWrite); end
    total++; if (WDSel !== 2'b00) begin bad++; $display("FAIL add_w_wdsel got=%b exp=00", WDSel); end
    total++; if (retire !== 1'b1) begin bad++; $display("FAIL add_w_retire got=%0b exp=1", retire); end
    step();
    total++; if (nrw !== 1) begin bad++; $display("FAIL add_regwrite_count got=%0d exp=1", nrw); end
    total++; if (MemRead !== 1'b1 || retire !== 1'b0) begin bad++; $display("FAIL add_next_fetch got=%b exp=10", {MemRead, retire}); end
    total++; if (instr_cnt !== 32'd1) begin bad++; $display("FAIL add_cnt got=%0d exp=1", instr_cnt); end
  endtask

  task automatic test_load();
    int cyc, nrw, nmr, nmw;
    logic [1:0] wd;
    logic [2:0] dm;
    set_ir(7'b0000011, 3'b010, 7'd0);
    run_instr(0, 3, cyc, nrw, nmr, nmw, wd, dm);
    total++; if (cyc !== 8) begin bad++; $display("FAIL lw_cycles got=%0d exp=8", cyc); end
    total++; if (nmr !== 5) begin bad++; $display("FAIL lw_memread_cycles got=%0d exp=5", nmr); end
    total++; if (wd !== 2'b01) begin bad++; $display("FAIL lw_wdsel got=%b exp=01", wd); end
    total++; if (dm !== 3'b010) begin bad++; $display("FAIL lw_dmtype got=%b exp=010", dm); end
    total++; if (nrw !== 1) begin bad++; $display("FAIL lw_regwrite got=%0d exp=1", nrw); end
    set_ir(7'b0000011, 3'b100, 7'd0);
    run_instr(2, 0, cyc, nrw, nmr, nmw, wd, dm);
    total++; if (cyc !== 7) begin bad++; $display("FAIL lbu_fetchwait_cycles got=%0d exp=7", cyc); end
    total++; if (nmr !== 4) begin bad++; $display("FAIL lbu_memread_cycles got=%0d exp=4", nmr); end
    total++; if (dm !== 3'b100) begin bad++; $display("FAIL lbu_dmtype got=%b exp=100", dm); end
  endtask

  task automatic test_store();
    int cyc, nrw, nmr, nmw;
    logic [1:0] wd;
    logic [2:0] dm;
    set_ir(7'b0100011, 3'b010, 7'd0);
    run_instr(0, 0, cyc, nrw, nmr, nmw, wd, dm);
    total++; if (cyc !== 4) begin bad++; $display("FAIL sw_cycles got=%0d exp=4", cyc); end
    total++; if (nmw !== 1) begin bad++; $display("FAIL sw_memwrite got=%0d exp=1", nmw); end
    total++; if (nrw !== 0) begin bad++; $display("FAIL sw_regwrite got=%0d exp=0", nrw); end
    total++; if (dm !== 3'b010) begin bad++; $display("FAIL sw_dmtype got=%b exp=010", dm); end
    set_ir(7'b0100011, 3'b001, 7'd0);
    run_instr(0, 2, cyc, nrw, nmr, nmw, wd, dm);
    total++; if (cyc !== 6) begin bad++; $display("FAIL sh_cycles got=%0d exp=6", cyc); end
    total++; if (nmw !== 3) begin bad++; $display("FAIL sh_memwrite got=%0d exp=3", nmw); end
    total++; if (dm !== 3'b001) begin bad++; $display("FAIL sh_dmtype got=%b exp=001", dm); end
    total++; if (instr_cnt !== 32'd5) begin bad++; $display("FAIL store_cnt got=%0d exp=5", instr_cnt); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b101, 3'b111, 3'b110};
    logic [2:0] flg [7] = '{3'b100, 3'b100, 3'b010, 3'b000, 3'b010, 3'b001, 3'b001};
    logic       tkn [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      set_ir(7'b1100011, f3s[i], 7'd0);
      {Zero, Lt, Ltu} = flg[i];
      step();
      step();
      total++; if (PCWrite !== tkn[i]) begin bad++; $display("FAIL br%0d_pcwrite got=%0b exp=%0b", i, PCWrite, tkn[i]); end
      total++; if (NPCOp !== {2'b00, tkn[i]}) begin bad++; $display("FAIL br%0d_npcop got=%b exp=%b", i, NPCOp, {2'b00, tkn[i]}); end
      total++; if (retire !== 1'b1 || RegWrite !== 1'b0) begin bad++; $display("FAIL br%0d_retire got=%b exp=10", i, {retire, RegWrite}); end
      total++; if (EXTOp !== 6'b000100) begin bad++; $display("FAIL br%0d_extop got=%b exp=000100", i, EXTOp); end
      step();
    end
    {Zero, Lt, Ltu} = 3'b000;
    total++; if (MemRead !== 1'b1 || instr_cnt !== 32'd12) begin bad++; $display("FAIL br_after got=%0b/%0d exp=1/12", MemRead, instr_cnt); end
  endtask

  task automatic test_jump();
    set_ir(7'b1101111, 3'b000, 7'd0);
    step();
    step();
    total++; if ({RegWrite, PCWrite, retire} !== 3'b111) begin bad++; $display("FAIL jal_strobes got=%b exp=111", {RegWrite, PCWrite, retire}); end
    total++; if (WDSel !== 2'b10) begin bad++; $display("FAIL jal_wdsel got=%b exp=10", WDSel); end
    total++; if (NPCOp !== 3'b010) begin bad++; $display("FAIL jal_npcop got=%b exp=010", NPCOp); end
    total++; if (EXTOp !== 6'b000001) begin bad++; $display("FAIL jal_extop got=%b exp=000001", EXTOp); end
    step();
    total++; if (MemRead !== 1'b1) begin bad++; $display("FAIL jal_next_fetch got=%0b exp=1", MemRead); end
    set_ir(7'b1100111, 3'b000, 7'd0);
    step();
    step();
    total++; if (NPCOp !== 3'b100) begin bad++; $display("FAIL jalr_npcop got=%b exp=100", NPCOp); end
    total++; if ({RegWrite, PCWrite, ALUSrc} !== 3'b111) begin bad++; $display("FAIL jalr_strobes got=%b exp=111", {RegWrite, PCWrite, ALUSrc}); end
    total++; if (EXTOp !== 6'b010000) begin bad++; $display("FAIL jalr_extop got=%b exp=010000", EXTOp); end
    step();
  endtask

  task automatic test_alu_variants();
    logic [6:0] ops [8] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0110011};
    logic [2:0] f3s [8] = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b100, 3'b000, 3'b000, 3'b011};
    logic [6:0] f7s [8] = '{7'h20, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    logic [4:0] aop [8] = '{5'd3, 5'd9, 5'd9, 5'd4, 5'd7, 5'd1, 5'd2, 5'd6};
    logic [1:0] src [8] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [5:0] ext [8] = '{6'h00, 6'h00, 6'h20, 6'h20, 6'h10, 6'h02, 6'h02, 6'h00};
    for (int i = 0; i < 8; i++) begin
      set_ir(ops[i], f3s[i], f7s[i]);
      step();
      step();
      total++; if (ALUOp !== aop[i]) begin bad++; $display("FAIL alu%0d_aluop got=%0d exp=%0d", i, ALUOp, aop[i]); end
      total++; if ({ALUSrc, ALUSrcA} !== src[i]) begin bad++; $display("FAIL alu%0d_src got=%b exp=%b", i, {ALUSrc, ALUSrcA}, src[i]); end
      total++; if (EXTOp !== ext[i]) begin bad++; $display("FAIL alu%0d_extop got=%b exp=%b", i, EXTOp, ext[i]); end
      step();
      total++; if ({RegWrite, WDSel, retire} !== 4'b1001) begin bad++; $display("FAIL alu%0d_wb got=%b exp=1001", i, {RegWrite, WDSel, retire}); end
      step();
    end
    total++; if (instr_cnt !== 32'd22 || illegal !== 1'b0) begin bad++; $display("FAIL alu_after got=%0d/%0b exp=22/0", instr_cnt, illegal); end
  endtask

  task automatic test_reset_mid_store();
    set_ir(7'b0100011, 3'b010, 7'd0);
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    total++; if (MemWrite !== 1'b1 || DMType !== 3'b010) begin bad++; $display("FAIL rstmem_pre got=%0b/%b exp=1/010", MemWrite, DMType); end
    reset = 1'b1;
    #1;
    total++; if ({MemWrite, MemRead, retire} !== 3'b000) begin bad++; $display("FAIL rstmem_gated got=%b exp=000", {MemWrite, MemRead, retire}); end
    step();
    reset = 1'b0;
    #1;
    total++; if (instr_cnt !== 32'd0) begin bad++; $display("FAIL rstmem_cnt got=%0d exp=0", instr_cnt); end
    total++; if ({MemRead, MemWrite, IRWrite} !== 3'b100) begin bad++; $display("FAIL rstmem_fetch got=%b exp=100", {MemRead, MemWrite, IRWrite}); end
    mem_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    do_reset();
    set_ir(7'b0010011, 3'b000, 7'd0);
    for (int c = 0; c < 64; c++) begin
      #1;
      if (c == 60) begin
        total++; if (s_instr_cnt !== 4'd15) begin bad++; $display("FAIL wrap_cnt15 got=%0d exp=15", s_instr_cnt); end
      end
      pulses += int'(s_retire);
      step();
    end
    total++; if (pulses !== 16) begin bad++; $display("FAIL wrap_pulses got=%0d exp=16", pulses); end
    total++; if (s_instr_cnt !== 4'd0) begin bad++; $display("FAIL wrap_cnt4 got=%0d exp=0", s_instr_cnt); end
    total++; if (instr_cnt !== 32'd16) begin bad++; $display("FAIL wrap_cnt32 got=%0d exp=16", instr_cnt); end
  endtask

  task automatic test_trap();
    int strobes;
    strobes = 0;
    set_ir(7'b1111111, 3'b000, 7'd0);
    step();
    step();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL trap_illegal got=%0b exp=1", illegal); end
    for (int c = 0; c < 10; c++) begin
      #1;
      strobes += int'(PCWrite | IRWrite | RegWrite | MemRead | MemWrite | retire);
      step();
    end
    total++; if (strobes !== 0) begin bad++; $display("FAIL trap_strobes got=%0d exp=0", strobes); end
    total++; if (illegal !== 1'b1 || instr_cnt !== 32'd16) begin bad++; $display("FAIL trap_hold got=%0b/%0d exp=1/16", illegal, instr_cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    total++; if ({illegal, MemRead} !== 2'b01 || instr_cnt !== 32'd0) begin bad++; $display("FAIL trap_reset got=%b/%0d exp=01/0", {illegal, MemRead}, instr_cnt); end
    set_ir(7'b0110011, 3'b000, 7'b0000001);
    step();
    step();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL trap_mul got=%0b exp=1", illegal); end
    do_reset();
    set_ir(7'b0010011, 3'b001, 7'b0100000);
    step();
    step();
    total++; if (illegal !== 1'b1 || ALUOp !== 5'd0) begin bad++; $display("FAIL trap_slli_f7 got=%0b/%0d exp=1/0", illegal, ALUOp); end
    do_reset();
    set_ir(7'b0000011, 3'b011, 7'd0);
    step();
    step();
    total++; if (illegal !== 1'b1) begin bad++; $display("FAIL trap_ld_f3 got=%0b exp=1", illegal); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_alu_variants();
    test_reset_mid_store();
    test_wrap();
    test_trap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
